// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, next-PC select encoding and alignment helper for pc_unit.
package pc_pkg;

   localparam int IALIGN_BYTES = 4;

   typedef enum logic [2:0] {
      NPC_SEQ,
      NPC_BR,
      NPC_JMP,
      NPC_XRET,
      NPC_TRAP,
      NPC_HOLD
   } npc_sel_e;

   // Only the low two address bits matter for 4-byte instruction alignment.
   function automatic logic is_misaligned(input logic [1:0] addr);
      return (32'(addr) % IALIGN_BYTES) != 0;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
   import pc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = $clog2(RAS_DEPTH);

   logic [XLEN-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   ptr;
   logic [PW:0]     cnt;
   logic [PW-1:0]   top_idx;

   // ptr names the next free slot; when full that slot holds the oldest entry.
   assign top_idx = ptr - PW'(1);
   assign empty   = cnt == '0;
   assign full    = cnt == (PW+1)'(RAS_DEPTH);
   assign top     = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      end else if (push && pop && !empty) begin
         mem[top_idx] <= din;
      end else if (push) begin
         mem[ptr] <= din;
         ptr      <= ptr + PW'(1);
         cnt      <= full ? cnt : cnt + (PW+1)'(1);
      end else if (pop && !empty) begin
         ptr <= top_idx;
         cnt <= cnt - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised redirect, misalignment rejection
// and a return-address stack for return prediction.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            xret_valid,
   input  logic [XLEN-1:0] epc,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_target,
   input  logic            jump_is_call,
   input  logic            jump_is_ret,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misalign,
   output logic [XLEN-1:0] badaddr,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(IALIGN_BYTES - 1);

   npc_sel_e        sel;
   logic [XLEN-1:0] tgt;
   logic            mis;
   logic [XLEN-1:0] pc_nxt;
   logic            ras_push;
   logic            ras_pop;

   assign pc_plus4 = pc + XLEN'(IALIGN_BYTES);

   always_comb begin
      sel = trap_valid ? NPC_TRAP :
            xret_valid ? NPC_XRET :
            !en        ? NPC_HOLD :
            jump_valid ? NPC_JMP  :
            br_taken   ? NPC_BR   : NPC_SEQ;
      tgt = jump_valid ? jump_target : br_target;
      mis = (sel == NPC_JMP || sel == NPC_BR) && is_misaligned(tgt[1:0]);
      pc_nxt = sel == NPC_TRAP ? trap_vec & ALIGN_MASK :
               sel == NPC_XRET ? epc & ALIGN_MASK      :
               sel == NPC_SEQ  ? pc_plus4              :
               sel == NPC_HOLD || mis ? pc : tgt;
      ras_push = sel == NPC_JMP && !mis && jump_is_call;
      ras_pop  = sel == NPC_JMP && !mis && jump_is_ret;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_VECTOR;
         misalign <= 1'b0;
         badaddr  <= '0;
      end else begin
         pc       <= pc_nxt;
         misalign <= mis;
         badaddr  <= mis ? tgt : badaddr;
      end
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc_plus4),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed expectations for pc_unit.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst, en, trap_valid, xret_valid, jump_valid, jump_is_call, jump_is_ret, br_taken;
   logic [31:0] trap_vec, epc, jump_target, br_target;
   logic [31:0] pc, pc_plus4, badaddr, ras_top;
   logic        misalign, ras_empty, ras_full;
   int          errs = 0;
   int          checks = 0;

   pc_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_1000),
      .RAS_DEPTH    (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .trap_valid   (trap_valid),
      .trap_vec     (trap_vec),
      .xret_valid   (xret_valid),
      .epc          (epc),
      .jump_valid   (jump_valid),
      .jump_target  (jump_target),
      .jump_is_call (jump_is_call),
      .jump_is_ret  (jump_is_ret),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .misalign     (misalign),
      .badaddr      (badaddr),
      .ras_top      (ras_top),
      .ras_empty    (ras_empty),
      .ras_full     (ras_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      trap_valid = 0; xret_valid = 0; jump_valid = 0; br_taken = 0;
      jump_is_call = 0; jump_is_ret = 0;
   endtask

   initial begin
      logic [31:0] exp_top [4];
      exp_top = '{32'h54, 32'h44, 32'h34, 32'h24};
      rst = 1; en = 0; clear();
      trap_vec = 0; epc = 0; jump_target = 0; br_target = 0;
      #12;
      chk("rst_pc", pc, 32'h1000);
      chk("rst_empty", 32'(ras_empty), 1);
      chk("rst_misalign", 32'(misalign), 0);
      chk("rst_badaddr", badaddr, 0);
      chk("rst_top", ras_top, 0);
      chk("pc_plus4", pc_plus4, 32'h1004);
      rst = 0; en = 1;
      tick(); chk("seq1", pc, 32'h1004);
      tick(); chk("seq2", pc, 32'h1008);
      tick(); chk("seq3", pc, 32'h100C);
      chk("seq_empty", 32'(ras_empty), 1);

      en = 0; br_taken = 1; br_target = 32'h200;
      tick(); chk("stall_hold", pc, 32'h100C);
      br_taken = 0; trap_valid = 1; trap_vec = 32'h103;
      tick(); chk("trap_stall", pc, 32'h100);

      en = 1; trap_vec = 32'h300; xret_valid = 1; epc = 32'h502;
      jump_valid = 1; jump_target = 32'h600; br_taken = 1; br_target = 32'h700;
      tick(); chk("prio_trap", pc, 32'h300);
      trap_valid = 0;
      tick(); chk("prio_xret", pc, 32'h500);
      chk("prio_ras", 32'(ras_empty), 1);
      clear();

      jump_valid = 1; jump_target = 32'h402; jump_is_call = 1;
      tick();
      chk("mis_pc", pc, 32'h500);
      chk("mis_flag", 32'(misalign), 1);
      chk("mis_bad", badaddr, 32'h402);
      chk("mis_ras", 32'(ras_empty), 1);
      clear();
      tick();
      chk("mis_drop", 32'(misalign), 0);
      chk("mis_seq", pc, 32'h504);
      br_taken = 1; br_target = 32'h201;
      tick();
      chk("brmis_pc", pc, 32'h504);
      chk("brmis_flag", 32'(misalign), 1);
      chk("brmis_bad", badaddr, 32'h201);
      trap_valid = 1; trap_vec = 32'hFFFF_FFFC;
      tick();
      chk("trap_clr_mis", 32'(misalign), 0);
      chk("trap_hi", pc, 32'hFFFF_FFFC);
      clear();
      tick(); chk("wrap", pc, 32'h0);

      trap_valid = 1; trap_vec = 32'h10;
      tick(); chk("to_10", pc, 32'h10);
      clear();
      jump_valid = 1; jump_is_call = 1;
      for (int i = 0; i < 5; i++) begin
         jump_target = 32'h20 + 32'(i) * 32'h10;
         tick();
         chk("call_pc", pc, jump_target);
         chk("call_top", ras_top, 32'h14 + 32'(i) * 32'h10);
         chk("call_full", 32'(ras_full), (i >= 3) ? 32'd1 : 32'd0);
      end
      jump_is_call = 0; jump_is_ret = 1; jump_target = 32'h100;
      for (int i = 0; i < 4; i++) begin
         chk("pop_top", ras_top, exp_top[i]);
         tick();
         chk("pop_full", 32'(ras_full), 0);
      end
      chk("pop_empty", 32'(ras_empty), 1);
      chk("pop_top0", ras_top, 0);
      tick();
      chk("pop5_empty", 32'(ras_empty), 1);
      chk("pop5_top", ras_top, 0);
      clear();

      trap_valid = 1; trap_vec = 32'h20;
      tick(); clear();
      jump_valid = 1; jump_is_call = 1; jump_target = 32'h80;
      tick();
      chk("c6_pc", pc, 32'h80);
      chk("c6_top", ras_top, 32'h24);
      jump_is_ret = 1; jump_target = 32'h90;
      tick();
      chk("cr_top", ras_top, 32'h84);
      chk("cr_empty", 32'(ras_empty), 0);
      chk("cr_full", 32'(ras_full), 0);
      jump_is_call = 0; jump_target = 32'hA0;
      tick();
      chk("cr_cnt1", 32'(ras_empty), 1);
      jump_is_call = 1; jump_is_ret = 0; jump_target = 32'hB0;
      tick();
      chk("pre_rst_top", ras_top, 32'hA4);
      clear();
      #2 rst = 1;
      #1;
      chk("arst_pc", pc, 32'h1000);
      chk("arst_empty", 32'(ras_empty), 1);
      chk("arst_top", ras_top, 0);
      rst = 0;
      tick(); chk("post_rst", pc, 32'h1004);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
